// File: rtl/fp_fma_dot_driver.sv
// fp_fma_dot_driver: issues element-pair multiplies to fp_fma and accumulates returning products into a dot product
module fp_fma_dot_driver #(
  parameter int ibits = 12,
  parameter int fbits = 20,
  parameter int id_bits = 8,
  parameter int len_bits = 16,
  parameter int max_outstanding = 16,
  localparam int W = ibits + fbits,
  localparam int RW = 2 * W + 1,
  localparam int AW = RW + len_bits
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [len_bits-1:0] length,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       result,
  output logic                error,
  input  logic [W-1:0]        elem_a,
  input  logic [W-1:0]        elem_b,
  input  logic                elem_valid,
  output logic                elem_ready,
  output logic [W-1:0]        fma_a,
  output logic [W-1:0]        fma_b,
  output logic [2*W-1:0]      fma_c,
  output logic [id_bits-1:0]  fma_iid,
  output logic                fma_ivalid,
  input  logic                fma_iready,
  input  logic [RW-1:0]       fma_r,
  input  logic [id_bits-1:0]  fma_oid,
  input  logic                fma_ovalid,
  output logic                fma_oacknowledge
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [len_bits-1:0] len_q, len_d, tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [id_bits-1:0] tx_id_q, tx_id_d, rx_id_q, rx_id_d;
  logic [AW-1:0] acc_q, acc_d, result_q, result_d;
  logic error_q, error_d;
  logic active, credit_ok, fire, accept, dup;
  always_comb begin
    active = state_q == ISSUE || state_q == DRAIN;
    credit_ok = tx_count_q - rx_count_q < len_bits'(max_outstanding);
    fma_a = elem_a;
    fma_b = elem_b;
    fma_c = '0;
    fma_iid = tx_id_q;
    fma_ivalid = elem_valid && credit_ok && state_q == ISSUE;
    elem_ready = fma_iready && credit_ok && state_q == ISSUE;
    fma_oacknowledge = 1'b1;
    busy = active;
    done = state_q == DONE;
    result = result_q;
    error = error_q;
    fire = fma_ivalid && fma_iready;
    accept = active && fma_ovalid && fma_oid == rx_id_q;
    dup = fma_oid == rx_id_q - id_bits'(1);
    state_d = state_q;
    len_d = len_q;
    tx_count_d = fire ? tx_count_q + len_bits'(1) : tx_count_q;
    tx_id_d = fire ? tx_id_q + id_bits'(1) : tx_id_q;
    rx_count_d = accept ? rx_count_q + len_bits'(1) : rx_count_q;
    rx_id_d = accept ? rx_id_q + id_bits'(1) : rx_id_q;
    acc_d = accept ? acc_q + {{(AW-RW){fma_r[RW-1]}}, fma_r} : acc_q;
    error_d = error_q || (active && fma_ovalid && !accept && !dup);
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        len_d = length;
        tx_count_d = '0;
        rx_count_d = '0;
        tx_id_d = '0;
        rx_id_d = '0;
        acc_d = '0;
        error_d = 1'b0;
        state_d = length == '0 ? DONE : ISSUE;
        result_d = length == '0 ? '0 : result_q;
      end
      ISSUE: state_d = tx_count_d == len_q ? DRAIN : ISSUE;
      DRAIN: if (rx_count_q == len_q) begin
        state_d = DONE;
        result_d = acc_d;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      tx_count_q <= '0;
      rx_count_q <= '0;
      tx_id_q <= '0;
      rx_id_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      tx_id_q <= tx_id_d;
      rx_id_q <= rx_id_d;
      acc_q <= acc_d;
      result_q <= result_d;
      error_q <= error_d;
    end
  end
endmodule

// File: tb/tb_fp_fma_dot_driver.sv
// tb_fp_fma_dot_driver: scoreboard bench driving the dot driver against a latency-8 fp_fma model
module tb_fp_fma_dot_driver;
  localparam int IB = 12, FB = 20, IDB = 8, LB = 16, MO = 4, LAT = 8;
  localparam int W = IB + FB, RW = 2 * W + 1, AW = RW + LB;
  typedef struct {int due; logic [IDB-1:0] id; logic [RW-1:0] r;} op_t;
  logic clock = 0, reset = 1, start = 0;
  logic [LB-1:0] length = '0;
  logic busy, done, error, elem_ready, fma_ivalid, fma_oacknowledge;
  logic [AW-1:0] result;
  logic [W-1:0] elem_a = '0, elem_b = '0, fma_a, fma_b;
  logic elem_valid = 0, fma_iready = 0, fma_ovalid = 0;
  logic [2*W-1:0] fma_c;
  logic [IDB-1:0] fma_iid, fma_oid = '0;
  logic [RW-1:0] fma_r = '0;
  op_t pipe[$];
  logic [AW-1:0] sb[$];
  logic signed [W-1:0] ea[$], eb[$];
  int vectors = 0, errors = 0, tick = 0, issues = 0, retires = 0, dones = 0;
  logic [IDB-1:0] exp_iid = '0, inj_id = '0;
  logic [RW-1:0] inj_r = '0;
  bit rstall = 0, istall = 0, inj = 0, saw_ivalid = 0, er_s = 0, iv_s = 0;
  always #5 clock = ~clock;
  fp_fma_dot_driver #(.ibits(IB), .fbits(FB), .id_bits(IDB), .len_bits(LB), .max_outstanding(MO)) dut (
    .clock(clock), .reset(reset), .start(start), .length(length), .busy(busy), .done(done),
    .result(result), .error(error), .elem_a(elem_a), .elem_b(elem_b), .elem_valid(elem_valid),
    .elem_ready(elem_ready), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_iid(fma_iid),
    .fma_ivalid(fma_ivalid), .fma_iready(fma_iready), .fma_r(fma_r), .fma_oid(fma_oid),
    .fma_ovalid(fma_ovalid), .fma_oacknowledge(fma_oacknowledge));
  function automatic logic signed [W-1:0] fx(real x);
    return $rtoi(x * 1048576.0);
  endfunction
  task automatic drive_elem();
    elem_valid = ea.size() > 0;
    elem_a = '0;
    elem_b = '0;
    if (elem_valid) begin
      elem_a = ea[0];
      elem_b = eb[0];
    end
  endtask
  task automatic drive_fma();
    fma_iready = !istall;
    fma_ovalid = inj || (!rstall && pipe.size() > 0 && pipe[0].due <= tick);
    fma_oid = '0;
    fma_r = '0;
    if (inj) begin
      fma_oid = inj_id;
      fma_r = inj_r;
    end else if (pipe.size() > 0) begin
      fma_oid = pipe[0].id;
      fma_r = pipe[0].r;
    end
  endtask
  task automatic cycle();
    bit iss, ret;
    logic signed [RW-1:0] p;
    logic [AW-1:0] exp_r;
    @(negedge clock);
    iss = fma_ivalid && fma_iready;
    ret = fma_ovalid && fma_oacknowledge && !inj;
    er_s = elem_ready;
    iv_s = fma_ivalid;
    if (fma_ivalid) saw_ivalid = 1;
    if (iss) begin
      vectors++;
      if (ea.size() == 0) begin
        errors++;
        $display("FAIL issue_extra: iid=%0d issued with no element pending, expected no issue", fma_iid);
      end else begin
        if (fma_iid !== exp_iid || fma_a !== ea[0] || fma_b !== eb[0]) begin
          errors++;
          $display("FAIL issue: iid=%0d a=%h b=%h, expected iid=%0d a=%h b=%h", fma_iid, fma_a, fma_b, exp_iid, ea[0], eb[0]);
        end
        p = ea[0] * eb[0];
        pipe.push_back('{tick + LAT, exp_iid, p});
        ea.pop_front();
        eb.pop_front();
      end
      exp_iid++;
      issues++;
    end
    if (done) begin
      dones++;
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done=1 result=%h, expected no done", result);
      end else begin
        exp_r = sb.pop_front();
        if (result !== exp_r) begin
          errors++;
          $display("FAIL result: got %h, expected %h", result, exp_r);
        end
      end
    end
    @(posedge clock);
    #1;
    tick++;
    if (ret && pipe.size() > 0) begin
      void'(pipe.pop_front());
      retires++;
    end
    drive_elem();
    drive_fma();
  endtask
  task automatic launch(input int n);
    logic signed [AW-1:0] s = '0;
    foreach (ea[i]) s = s + ea[i] * eb[i];
    sb.push_back(s);
    issues = 0;
    retires = 0;
    dones = 0;
    exp_iid = '0;
    saw_ivalid = 0;
    drive_elem();
    start = 1;
    length = LB'(n);
    cycle();
    start = 0;
  endtask
  task automatic wait_done(input int budget, output int used);
    int d0 = dones;
    used = 0;
    while (dones == d0 && used < budget) begin
      cycle();
      used++;
    end
    vectors++;
    if (dones == d0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, expected one", budget);
    end
  endtask
  task automatic wait_retires(input int n);
    int k = 0;
    while (retires < n && k < 200) begin
      cycle();
      k++;
    end
    vectors++;
    if (retires < n) begin
      errors++;
      $display("FAIL retire_timeout: retires=%0d, expected %0d", retires, n);
    end
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) cycle();
    vectors += 4;
    if (busy !== 0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (done !== 0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
    if (result !== '0) begin errors++; $display("FAIL reset_result: got %h, expected 0", result); end
    if (error !== 0) begin errors++; $display("FAIL reset_error: got %b, expected 0", error); end
    reset = 0;
    cycle();
    vectors += 4;
    if (iv_s !== 0) begin errors++; $display("FAIL idle_ivalid: got %b, expected 0", iv_s); end
    if (er_s !== 0) begin errors++; $display("FAIL idle_elem_ready: got %b, expected 0", er_s); end
    if (fma_oacknowledge !== 1) begin errors++; $display("FAIL oack: got %b, expected 1", fma_oacknowledge); end
    if (fma_c !== '0) begin errors++; $display("FAIL fma_c: got %h, expected 0", fma_c); end
  endtask
  task automatic test_basic();
    int used;
    real av[4] = '{1.0, 2.0, -1.5, 0.5};
    real bv[4] = '{2.0, 0.5, 2.0, 4.0};
    logic [AW-1:0] two = AW'(64'h200_0000_0000);
    foreach (av[i]) begin
      ea.push_back(fx(av[i]));
      eb.push_back(fx(bv[i]));
    end
    vectors++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_stale: got %0d entries, expected 0", sb.size()); end
    launch(4);
    vectors++;
    if (busy !== 1) begin errors++; $display("FAIL busy_after_start: got %b, expected 1", busy); end
    wait_done(200, used);
    repeat (3) cycle();
    vectors += 5;
    if (result !== two) begin errors++; $display("FAIL basic_result: got %h, expected %h", result, two); end
    if (issues != 4) begin errors++; $display("FAIL basic_issues: got %0d, expected 4", issues); end
    if (dones != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d, expected 1", dones); end
    if (error !== 0) begin errors++; $display("FAIL basic_error: got %b, expected 0", error); end
    if (busy !== 0) begin errors++; $display("FAIL basic_busy: got %b, expected 0", busy); end
  endtask
  task automatic test_zero_len();
    int used;
    launch(0);
    wait_done(10, used);
    vectors += 3;
    if (saw_ivalid) begin errors++; $display("FAIL zero_ivalid: got 1, expected 0"); end
    if (used > 2) begin errors++; $display("FAIL zero_latency: got %0d cycles, expected <=2", used); end
    if (busy !== 0) begin errors++; $display("FAIL zero_busy: got %b, expected 0", busy); end
  endtask
  task automatic test_credit();
    int used;
    for (int i = 0; i < 10; i++) begin
      ea.push_back(fx(0.5 * (i + 1)));
      eb.push_back(fx(1.25 * (i % 3 - 1)));
    end
    rstall = 1;
    launch(10);
    repeat (20) cycle();
    vectors += 2;
    if (issues != MO) begin errors++; $display("FAIL credit_issues: got %0d, expected %0d", issues, MO); end
    if (er_s !== 0) begin errors++; $display("FAIL credit_elem_ready: got %b, expected 0", er_s); end
    rstall = 0;
    drive_fma();
    wait_done(400, used);
    vectors++;
    if (issues != 10) begin errors++; $display("FAIL credit_total: got %0d, expected 10", issues); end
  endtask
  task automatic test_iready_stall();
    int used, snap, k = 0;
    for (int i = 0; i < 6; i++) begin
      ea.push_back(fx(-0.75 * i + 1.0));
      eb.push_back(fx(0.125 * (i + 3)));
    end
    launch(6);
    while (issues < 2 && k < 100) begin
      cycle();
      k++;
    end
    istall = 1;
    cycle();
    snap = issues;
    repeat (20) cycle();
    vectors += 2;
    if (issues != snap) begin errors++; $display("FAIL stall_issues: got %0d, expected %0d", issues, snap); end
    if (fma_iid !== exp_iid) begin errors++; $display("FAIL stall_tx_id: got %0d, expected %0d", fma_iid, exp_iid); end
    istall = 0;
    drive_fma();
    wait_done(400, used);
    vectors++;
    if (issues != 6) begin errors++; $display("FAIL stall_total: got %0d, expected 6", issues); end
  endtask
  task automatic test_bad_oid();
    int used;
    for (int i = 0; i < 3; i++) begin
      ea.push_back(fx(1.5 + i));
      eb.push_back(fx(-2.0 + i));
    end
    launch(3);
    wait_retires(1);
    rstall = 1;
    inj = 1;
    inj_r = RW'(64'h100_0000_0000);
    inj_id = IDB'(retires - 1);
    drive_fma();
    cycle();
    vectors++;
    if (error !== 0) begin errors++; $display("FAIL dup_error: got %b, expected 0", error); end
    inj_id = IDB'(retires + 5);
    drive_fma();
    cycle();
    vectors++;
    if (error !== 1) begin errors++; $display("FAIL bad_oid_error: got %b, expected 1", error); end
    inj = 0;
    rstall = 0;
    drive_fma();
    wait_done(400, used);
    vectors++;
    if (error !== 1) begin errors++; $display("FAIL error_sticky: got %b, expected 1", error); end
  endtask
  task automatic test_reset_mid();
    int used;
    for (int i = 0; i < 6; i++) begin
      ea.push_back(fx(0.25 + i));
      eb.push_back(fx(3.0 - i));
    end
    launch(6);
    wait_retires(2);
    reset = 1;
    cycle();
    reset = 0;
    vectors += 3;
    if (busy !== 0) begin errors++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
    if (result !== '0) begin errors++; $display("FAIL midreset_result: got %h, expected 0", result); end
    if (error !== 0) begin errors++; $display("FAIL midreset_error: got %b, expected 0", error); end
    pipe.delete();
    ea.delete();
    eb.delete();
    sb.delete();
    drive_fma();
    ea.push_back(fx(-3.5));
    eb.push_back(fx(1.5));
    ea.push_back(fx(2.25));
    eb.push_back(fx(-0.5));
    launch(2);
    wait_done(200, used);
    vectors++;
    if (issues != 2) begin errors++; $display("FAIL fresh_issues: got %0d, expected 2", issues); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_credit();
    test_iready_stall();
    test_bad_oid();
    test_reset_mid();
    repeat (3) cycle();
    vectors++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries, expected 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp_fma_dot_driver.md
Name: fp_fma_dot_driver

Overview:
- Initiator for the fp_fma pipeline. Drives the a/b/c/iid/ivalid side and consumes the r/oid/ovalid side.
- Accepts a stream of length fixed-point element pairs and issues one multiply per pair with c=0.
- Tags each issue with a sequential id and accumulates the returning products into a wide dot-product result.
- Sits between the RANSAC model-evaluation datapath and an fp_fma instance; owns credit tracking and result bookkeeping.

Parameters:
- ibits, 12, integer bits of a/b.
- fbits, 20, fraction bits of a/b.
- id_bits, 8, width of fma_iid/fma_oid.
- len_bits, 16, width of the length request.
- max_outstanding, 16, maximum issued-but-unretired ops; must be < 2^id_bits.

Ports:
(W = ibits+fbits, RW = 2*W+1, AW = RW+len_bits)
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a dot product; sampled only in IDLE.
- length  in  len_bits  number of element pairs; sampled with start.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse; result valid.
- result  out  AW  signed Q(2*ibits+1+len_bits).(2*fbits) sum; held until next accepted start.
- error  out  1  sticky; unexpected fma_oid seen.
- elem_a, elem_b  in  W each  signed operands.
- elem_valid  in  1  / elem_ready  out  1  element handshake.
- fma_a, fma_b  out  W each  operands to fp_fma.
- fma_c  out  2*W  constant 0.
- fma_iid  out  id_bits  issue tag.
- fma_ivalid  out  1 / fma_iready  in  1  issue handshake.
- fma_r  in  RW  product from fp_fma.
- fma_oid  in  id_bits  result tag.
- fma_ovalid  in  1 / fma_oacknowledge  out  1  result handshake.

Behaviour:
- Reset values: busy=0, done=0, result=0, error=0, state=IDLE, all counters/ids=0.
- Reset mid-operation: immediate return to IDLE; partial sum discarded.
- States:
  - IDLE: start with length>0 moves to ISSUE; clears acc, tx_count, rx_count, tx_id, rx_id, error.
  - IDLE: start with length=0 moves to DONE with acc=0.
  - IDLE: start while busy is ignored.
  - ISSUE: moves to DRAIN on the cycle tx_count reaches length.
  - DRAIN: moves to DONE when rx_count==length.
  - DONE: result<=acc, done=1 for exactly one cycle, then IDLE.
- Credit: outstanding = tx_count - rx_count; credit_ok = outstanding < max_outstanding. An issue and a retire in the same cycle leave outstanding unchanged.
- Issue path (combinational pass-through):
  - fma_a=elem_a, fma_b=elem_b, fma_iid=tx_id, fma_c=0.
  - fma_ivalid = elem_valid & credit_ok & state==ISSUE.
  - elem_ready = fma_iready & credit_ok & state==ISSUE.
  - Transfer occurs when fma_ivalid & fma_iready; tx_id and tx_count then increment, tx_id wrapping mod 2^id_bits.
  - fma_iready is registered in fp_fma; no assumption that it responds within the same cycle.
- Retire path:
  - fma_oacknowledge=1 in every state, so the pipeline never wedges.
  - Accept when fma_ovalid & fma_oid==rx_id & state in {ISSUE,DRAIN}: acc += sign-extend(fma_r) to AW, rx_id++ (wraps), rx_count++.
  - fma_ovalid with fma_oid==rx_id-1 (duplicate from registered output after ack): ignored silently.
  - Any other fma_oid while ISSUE/DRAIN: ignored, error<=1.
  - Any fma_ovalid in IDLE/DONE: discarded, no error.
- Results arrive in issue order; no reordering buffer.
- Accumulator width AW guarantees no overflow for length ≤ 2^len_bits-1.
- Latency: done follows the final accepted retire by 2 cycles (DRAIN→DONE transition, then DONE pulse).

Test Plan:
- Q12.20, length=4, a=(1.0,2.0,-1.5,0.5), b=(2.0,0.5,2.0,4.0), fp_fma latency 8 -> four issues with iid 0..3, done pulses once, result=2.0 (0x200_0000_0000), error=0.
- start with length=0 -> fma_ivalid never asserted, done high 2 cycles later, result=0, busy drops.
- max_outstanding=4, length=10, result side stalled (fp_fma model holds ovalid=0) -> exactly 4 issues then elem_ready=0; releasing stall completes all 10, result correct.
- fma_iready forced low 20 cycles mid-stream -> no transfers, no tx_id advance; resumes with no lost or duplicated element.
- Inject a repeat of the previous oid after a valid retire -> acc unchanged, error=0; inject oid=rx_id+5 -> error=1, acc unchanged.
- Assert reset after 2 of 6 retires -> next cycle busy=0, result=0, error=0; a new start with length=2 computes a correct fresh sum.
